// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants and types for the multi-port register file.
//   - reset / enable polarities, zero word
//   - FSM state encoding (RF_CLEAR sweeps the array, RF_RUN is normal use)
package regfile_mp_pkg;

  localparam logic        RstEnable   = 1'b0;
  localparam logic        RstDisable  = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic        ReadEnable  = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per architectural register.
// Ports:
//   clk_i, rst_i       clock, synchronous active-low reset
//   clr_en_i           sweep active: clear busy[clr_addr_i], ignore we/alloc
//   clr_addr_i         entry being swept
//   we_i, waddr_i      write ports (already gated to RUN by the parent)
//   alloc_i            mark alloc_addr_i busy (already gated to RUN)
//   alloc_addr_i       destination being allocated
//   busy_o             registered busy vector, bit r for register r
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned NWR  = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_en_i,
  input  logic [AW-1:0]     clr_addr_i,
  input  logic [NWR-1:0]    we_i,
  input  logic [NWR*AW-1:0] waddr_i,
  input  logic              alloc_i,
  input  logic [AW-1:0]     alloc_addr_i,
  output logic [NREG-1:0]   busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Writes clear first, then the allocation sets, so a same-cycle alloc and
  // write to one register leaves it busy: the newly issued producer wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) begin
      busy_d[clr_addr_i] = 1'b0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (we_i[k] == WriteEnable && waddr_i[k*AW +: AW] != '0) begin
          busy_d[waddr_i[k*AW +: AW]] = 1'b0;
        end
      end
      if (alloc_i && alloc_addr_i != '0) begin
        busy_d[alloc_addr_i] = 1'b1;
      end
    end
  end

  // No reset term: the post-reset sweep clears every bit, and updates arriving
  // in the reset cycle are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i == RstDisable) begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
// Ports:
//   clk_i, rst_i          clock, synchronous active-low reset
//   we_i/waddr_i/wdata_i  NWR write ports; higher port index wins on conflicts
//   re_i/raddr_i          NRD read ports
//   rdata_o               combinational read data with same-cycle write bypass
//   rbusy_o               registered busy bit of each read address
//   alloc_i/alloc_addr_i  mark a destination busy at issue
//   ready_o               high once the post-reset zero sweep has completed
//   dbg_state_o           current FSM state (RF_CLEAR / RF_RUN)
// Handshake: there is no backpressure. Writes and allocs are accepted on every
// posedge while ready_o is high and ignored otherwise; reads are valid in any
// cycle where ready_o is high and return zero otherwise.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*AW-1:0]   waddr_i,
  input  logic [NWR*XLEN-1:0] wdata_i,
  input  logic [NRD-1:0]      re_i,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]      rbusy_o,
  input  logic                alloc_i,
  input  logic [AW-1:0]       alloc_addr_i,
  output logic                ready_o,
  output logic                dbg_state_o
);

  rf_state_e        state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [NREG-1:0]  busy;
  logic             run;
  logic [NWR-1:0]   we_run;
  logic             alloc_run;

  assign run       = (state_q == RF_RUN);
  assign we_run    = run ? we_i : '0;
  assign alloc_run = run & alloc_i;

  // FSM: CLEAR walks cnt over every entry once, then RUN until the next reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RF_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(NREG - 1)) begin
        state_d = RF_RUN;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array update: iterating ports in ascending order lets the highest-index
  // port overwrite lower ones targeting the same register. x0 is never written.
  always_comb begin
    regs_d = regs_q;
    if (state_q == RF_CLEAR) begin
      regs_d[cnt_q] = XLEN'(ZeroWord);
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (we_run[k] == WriteEnable && waddr_i[k*AW +: AW] != '0) begin
          regs_d[waddr_i[k*AW +: AW]] = wdata_i[k*XLEN +: XLEN];
        end
      end
    end
  end

  // The array is initialised by the sweep rather than by reset; writes in the
  // reset cycle are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i == RstDisable) begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_en_i     (~run),
    .clr_addr_i   (cnt_q),
    .we_i         (we_run),
    .waddr_i      (waddr_i),
    .alloc_i      (alloc_run),
    .alloc_addr_i (alloc_addr_i),
    .busy_o       (busy)
  );

  // Read ports: bypass from the highest-index matching write port, else the
  // array. rbusy reflects registered state only, so a same-cycle write does
  // not clear it early.
  always_comb begin
    rdata_o = '0;
    rbusy_o = '0;
    for (int j = 0; j < NRD; j++) begin
      if (run && re_i[j] == ReadEnable && raddr_i[j*AW +: AW] != '0) begin
        rdata_o[j*XLEN +: XLEN] = regs_q[raddr_i[j*AW +: AW]];
        for (int k = 0; k < NWR; k++) begin
          if (we_i[k] == WriteEnable && waddr_i[k*AW +: AW] == raddr_i[j*AW +: AW]) begin
            rdata_o[j*XLEN +: XLEN] = wdata_i[k*XLEN +: XLEN];
          end
        end
        rbusy_o[j] = busy[raddr_i[j*AW +: AW]];
      end
    end
  end

  assign ready_o     = run;
  assign dbg_state_o = state_q;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the next core generation; replaces the 2-read/1-write regfile between ID (reads) and WB (writes). It adds configurable read/write port counts, write-port priority, same-cycle write-to-read bypass per port, a busy-bit scoreboard for in-flight destinations, and a post-reset sweep that zeroes the array.

## Interface
- XLEN, 32, register width
- NREG, 32, register count (power of two, ≥2); AW = log2(NREG)
- NRD, 2, read ports
- NWR, 2, write ports
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-low (rst_i==0 resets on posedge clk_i)
- we_i  in  NWR  per-port write enable
- waddr_i  in  NWR*AW  write addresses, port k at [k*AW +: AW]
- wdata_i  in  NWR*XLEN  write data, port k at [k*XLEN +: XLEN]
- re_i  in  NRD  per-port read enable
- raddr_i  in  NRD*AW  read addresses
- rdata_o  out  NRD*XLEN  read data (combinational)
- rbusy_o  out  NRD  busy bit of raddr for each read port (combinational)
- alloc_i  in  1  mark alloc_addr_i busy (issue of an instruction writing it)
- alloc_addr_i  in  AW  destination being allocated
- ready_o  out  1  array valid; high only in RUN

## Operation
- FSM states CLEAR, RUN. Reset → CLEAR, sweep counter = 0.
- CLEAR: each cycle writes 0 to regs[cnt] and clears busy[cnt], cnt++; after writing entry NREG-1 → RUN. we_i/alloc_i ignored.
- RUN: for each register r, if any port k has we_i[k] && waddr==r && r!=0, regs[r] <= wdata of highest-index such port.
- Register 0: never written; reads return 0; busy[0] never set.
- Read port j: raddr==0 or re_i[j]==0 → 0; else if any write port targets raddr this cycle with we set → wdata of highest-index matching port (bypass); else regs[raddr].
- Scoreboard: write to r clears busy[r]; alloc_i sets busy[alloc_addr_i]. Same-cycle alloc and write to same r: busy stays 1 (new producer wins).
- rbusy_o[j] = busy[raddr] if re_i[j] and raddr!=0, else 0; not affected by same-cycle bypass clear (reflects registered state).
- In CLEAR: rdata_o = 0, rbusy_o = 0, ready_o = 0.

## Timing
- Reset outputs: ready_o=0, rdata_o=0, rbusy_o=0.
- ready_o rises NREG cycles after the first posedge with rst_i==1.
- Write latency: stored at the posedge; visible via bypass in the same cycle, via array from next cycle.
- Alloc latency: busy visible on rbusy_o the cycle after alloc_i.
- Reset asserted mid-RUN or mid-CLEAR: next posedge returns to CLEAR, cnt=0, full sweep repeats; in-flight writes that cycle are dropped.
- Write to r and read of r on same cycle, two write ports to same r: higher index wins for both array and bypass.

## Structure
- Shared defines header: RstEnable (1'b0), RstDisable, WriteEnable, ReadEnable, ZeroWord, state encodings RF_CLEAR/RF_RUN.
- Sub-module regfile_scoreboard: busy bit vector, alloc/clear logic, clear-on-sweep input; parametrised by NREG, NWR.
- Data array, write priority, bypass muxes and FSM in regfile_mp.

## Test plan
- Reset then release: ready_o low 32 cycles, high on cycle 32; all reads of x1..x31 return 0.
- RUN, port0 writes x5=0xDEADBEEF, read x5 same cycle → 0xDEADBEEF (bypass); next cycle with we low → 0xDEADBEEF.
- Ports 0 and 1 both write x7 (0x11, 0x22) → read x7 returns 0x22 same cycle and after.
- Write x0=0xFFFF_FFFF → reads of x0 return 0; alloc x0 → rbusy 0.
- alloc x9 → rbusy for x9 = 1 next cycle; port1 writes x9 → rbusy 0 next cycle; alloc+write x9 same cycle → rbusy stays 1.
- Reset pulsed at cycle 10 of RUN with x3=0x55: ready_o drops, sweep 32 cycles, x3 reads 0 afterward; writes during CLEAR have no effect.
